// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier sequencer.
// The FSM state encoding and Booth digit decode are used by the top and the encoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 recoding of {b[2k+1], b[2k], b[2k-1]} into a digit in -2..+2
    function automatic logic signed [2:0] booth_digit(input logic [2:0] code);
        case (code)
            3'b001, 3'b010: booth_digit = 3'sd1;
            3'b011:         booth_digit = 3'sd2;
            3'b100:         booth_digit = -3'sd2;
            3'b101, 3'b110: booth_digit = -3'sd1;
            default:        booth_digit = 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_sequencer_enc.sv
// Radix-4 Booth partial-product generator: digit(group) * multiplicand, weighted by 4^k.
// Output is 2*N_BITS+1 bits so -2 * most-negative still fits before the weight shift.
module BoothEncoder
    import booth_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic [2:0]          booth_group,
    input  logic [4:0]          group_index,
    input  logic [N_BITS-1:0]   multiplicand,
    output logic [2*N_BITS:0]   partial_product_out
);

    logic [2*N_BITS:0] w_mcand_ext;
    logic [2*N_BITS:0] w_pp_unshifted;
    logic [2:0]        w_digit;

    always_comb begin
        w_mcand_ext = {{(N_BITS+1){multiplicand[N_BITS-1]}}, multiplicand};
        w_digit     = booth_digit(booth_group);
        case (w_digit)
            3'b001:  w_pp_unshifted = w_mcand_ext;
            3'b010:  w_pp_unshifted = w_mcand_ext << 1;
            3'b111:  w_pp_unshifted = -w_mcand_ext;
            3'b110:  w_pp_unshifted = -(w_mcand_ext << 1);
            default: w_pp_unshifted = '0;
        endcase
        partial_product_out = w_pp_unshifted << {group_index, 1'b0};
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Iterative radix-4 Booth multiplier: one multiplier group per clock, fixed latency,
// valid/ready on both the operand and product sides.
module booth_mul_sequencer
    import booth_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     multiplicand,
    input  logic [N_BITS-1:0]     multiplier,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_BITS-1:0]   product,
    output logic                  busy
);

    localparam int N_GROUPS = N_BITS / 2;
    localparam int CW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GROUP = CW'(N_GROUPS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [N_BITS-1:0]    r_mcand;
    logic [N_BITS-1:0]    r_mplr;
    logic [2*N_BITS:0]    r_acc;
    logic [CW-1:0]        r_count;
    logic [2*N_BITS-1:0]  r_product;

    logic [N_BITS:0]      w_mplr_ext;
    logic [2:0]           w_groups [N_GROUPS];
    logic [2:0]           w_booth_group;
    logic [2*N_BITS:0]    w_pp;
    logic [2*N_BITS:0]    w_acc_sum;
    logic                 w_last;

    // Appending a zero below the LSB supplies the implicit mplr[-1]
    assign w_mplr_ext = {r_mplr, 1'b0};

    for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_group
        assign w_groups[gi] = w_mplr_ext[2*gi +: 3];
    end

    assign w_booth_group = w_groups[r_count];
    assign w_acc_sum     = r_acc + w_pp;
    assign w_last        = (r_count == LAST_GROUP);

    BoothEncoder #(.N_BITS(N_BITS)) u_enc (
        .booth_group         (w_booth_group),
        .group_index         (5'(r_count)),
        .multiplicand        (r_mcand),
        .partial_product_out (w_pp)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= multiplicand;
                        r_mplr  <= multiplier;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_sum;
                    // Separate product register keeps the result stable after the next accept clears r_acc
                    if (w_last) r_product <= w_acc_sum[2*N_BITS-1:0];
                    else        r_count   <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed and random checks of the Booth sequencer: products, latency, backpressure, reset abort.
module tb_booth_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int excl_viol = 0;

    always #5 clk = ~clk;

    booth_mul_sequencer #(.N_BITS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always @(negedge clk) if (in_ready && out_valid) excl_viol++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present operands and wait until the accepting edge has passed; returns at the first RUN negedge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        mcand_drive(a, b);
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic mcand_drive(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
    endtask

    // Counts negedges from the accepting cycle (cycle 0) until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_hold"}, product, exp);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int lat;
        @(negedge clk);
        start_op(a, b);
        wait_done(lat);
        check({tag, "_prod"}, product, exp);
        check({tag, "_lat"}, 64'(lat), 64'd17);
        $display("op %s: %h x %h -> %h lat %0d", tag, a, b, product, lat);
        finish_op(tag, exp);
    endtask

    initial begin
        logic [63:0] held;
        logic        stable;
        logic        saw_ov;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand = 32'h1234_5678; multiplier = 32'h9abc_def0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;

        do_op("3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
        do_op("m7x6",  32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6);
        do_op("m1xm1", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
        do_op("0xmax", 32'd0,          32'h7FFF_FFFF,  64'h0);
        do_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        do_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // Backpressure: product held, new operands refused while DONE
        @(negedge clk);
        start_op(32'd1000, 32'hFFFF_FC18);
        wait_done(lat);
        held = product;
        stable = 1'b1;
        mcand_drive(32'd7, 32'd7);
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (product !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", {63'd0, stable}, 64'd1);
        check("bp_prod", product, 64'hFFFF_FFFF_FFF0_BDC0);
        $display("op bp: 1000 x -1000 -> %h", product);
        finish_op("bp", 64'hFFFF_FFFF_FFF0_BDC0);

        // Reset abort in the middle of RUN
        @(negedge clk);
        start_op(32'd99, 32'd77);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_idle", {62'd0, in_ready, busy}, 64'd2);
        saw_ov = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        check("abort_no_ov", {63'd0, saw_ov}, 64'd0);
        check("abort_prod", product, 64'd0);
        $display("op abort: no result");
        do_op("12xm12", 32'd12, 32'hFFFF_FFF4, 64'hFFFF_FFFF_FFFF_FF70);

        // Random signed pairs with idle and backpressure gaps
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            logic [63:0] exp;
            a = $urandom;
            b = $urandom;
            if (i % 50 == 0) a = 32'h8000_0000;
            if (i % 70 == 0) b = 32'h8000_0000;
            exp = 64'($signed(a) * $signed(b));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_op(a, b);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand_prod", product, exp);
            $display("rnd %0d: %h x %h -> %h", i, a, b, product);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("excl_ready_valid", 64'(excl_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
